// File: rtl/carbon_arch_pkg.sv
// Shared fabric architecture definitions: scheduler state encoding and default widths.
package carbon_arch_pkg;

  localparam int unsigned CARBON_FABRIC_SCHED_WEIGHT_W = 4;

  typedef enum logic [0:0] {
    SCHED_IDLE   = 1'b0,
    SCHED_LOCKED = 1'b1
  } fabric_sched_state_e;

  // Modular increment with an explicit compare so non-power-of-two counts wrap correctly.
  function automatic int unsigned fabric_wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fabric_wrr_scheduler_if.sv
// Grant/config bundle between the fabric request mux and the WRR scheduler.
interface fabric_wrr_scheduler_if
  import carbon_arch_pkg::*;
#(
  parameter int unsigned M   = 4,
  parameter int unsigned W_W = CARBON_FABRIC_SCHED_WEIGHT_W,
  parameter int unsigned M_W = $clog2(M)
);
  logic [M-1:0]   req_i;
  logic           xfer_i;
  logic           cfg_we_i;
  logic [M_W-1:0] cfg_idx_i;
  logic [W_W-1:0] cfg_weight_i;
  logic           gnt_valid_o;
  logic [M-1:0]   gnt_oh_o;
  logic [M_W-1:0] gnt_idx_o;
  logic           reload_o;

  modport master (
    output req_i, xfer_i, cfg_we_i, cfg_idx_i, cfg_weight_i,
    input  gnt_valid_o, gnt_oh_o, gnt_idx_o, reload_o
  );

  modport slave (
    input  req_i, xfer_i, cfg_we_i, cfg_idx_i, cfg_weight_i,
    output gnt_valid_o, gnt_oh_o, gnt_idx_o, reload_o
  );
endinterface

// File: rtl/fabric_rr_pick.sv
// Combinational round-robin picker: first set bit of req_vec_i scanning upward from start_i.
module fabric_rr_pick
  import carbon_arch_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [IDX_W-1:0] start_i,
  input  logic [N-1:0]     req_vec_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  always_comb begin
    int unsigned w_pos;
    logic        w_hit;
    w_hit = 1'b0;
    idx_o = '0;
    w_pos = 32'(start_i);
    for (int unsigned k = 0; k < N; k++) begin
      if (!w_hit && req_vec_i[w_pos[IDX_W-1:0]]) begin
        w_hit = 1'b1;
        idx_o = w_pos[IDX_W-1:0];
      end
      w_pos = fabric_wrap_inc(w_pos, N);
    end
    found_o = w_hit;
  end

endmodule

// File: rtl/fabric_wrr_scheduler.sv
// Weighted round-robin grant scheduler sharing one fabric slave port among M requesters.
module fabric_wrr_scheduler
  import carbon_arch_pkg::*;
#(
  parameter int unsigned M              = 4,
  parameter int unsigned W_W            = CARBON_FABRIC_SCHED_WEIGHT_W,
  parameter int unsigned DEFAULT_WEIGHT = 1
) (
  input logic                  clk,
  input logic                  rst,
  fabric_wrr_scheduler_if.slave bus
);

  localparam int unsigned    M_W       = $clog2(M);
  localparam logic [0:0]     ST_IDLE   = SCHED_IDLE;
  localparam logic [0:0]     ST_LOCKED = SCHED_LOCKED;
  localparam logic [W_W-1:0] W_DEFAULT = W_W'(DEFAULT_WEIGHT);

  logic [0:0]     r_state, w_state_d;
  logic [W_W-1:0] r_weight [M];
  logic [W_W-1:0] w_weight_d [M];
  logic [W_W-1:0] r_credit [M];
  logic [W_W-1:0] w_credit_d [M];
  logic [M_W-1:0] r_rr_ptr, w_rr_ptr_d;
  logic [M_W-1:0] r_gnt_idx, w_gnt_idx_d;
  logic [M-1:0]   r_gnt_oh, w_gnt_oh_d;
  logic           r_gnt_valid, w_gnt_valid_d;
  logic           r_reload, w_reload_d;

  logic [M-1:0]   w_eligible;
  logic [M-1:0]   w_live;
  logic           w_found;
  logic [M_W-1:0] w_pick_idx;
  logic           w_cfg_hit;

  always_comb begin
    for (int unsigned i = 0; i < M; i++) begin
      w_eligible[i] = bus.req_i[i] && (r_credit[i] != '0);
      w_live[i]     = bus.req_i[i] && (r_weight[i] != '0);
    end
  end

  fabric_rr_pick #(
    .N     (M),
    .IDX_W (M_W)
  ) u_pick (
    .start_i   (r_rr_ptr),
    .req_vec_i (w_eligible),
    .found_o   (w_found),
    .idx_o     (w_pick_idx)
  );

  assign w_cfg_hit = bus.cfg_we_i && (32'(bus.cfg_idx_i) < M);

  always_comb begin
    w_state_d     = r_state;
    w_rr_ptr_d    = r_rr_ptr;
    w_gnt_idx_d   = r_gnt_idx;
    w_gnt_oh_d    = r_gnt_oh;
    w_gnt_valid_d = r_gnt_valid;
    w_reload_d    = 1'b0;
    w_weight_d    = r_weight;
    w_credit_d    = r_credit;

    // Weight lands first so a same-cycle reload picks up the new value.
    if (w_cfg_hit) begin
      w_weight_d[bus.cfg_idx_i] = bus.cfg_weight_i;
    end

    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_d     = ST_LOCKED;
          w_gnt_valid_d = 1'b1;
          w_gnt_idx_d   = w_pick_idx;
          w_gnt_oh_d    = M'(1) << w_pick_idx;
        end else if (|w_live) begin
          w_credit_d = w_weight_d;
          w_reload_d = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (bus.xfer_i || !bus.req_i[r_gnt_idx]) begin
          w_state_d     = ST_IDLE;
          w_gnt_valid_d = 1'b0;
          w_gnt_idx_d   = '0;
          w_gnt_oh_d    = '0;
        end
        if (bus.xfer_i) begin
          w_credit_d[r_gnt_idx] = r_credit[r_gnt_idx] - W_W'(1);
          // Winner keeps priority until its burst of credits is spent.
          w_rr_ptr_d = (w_credit_d[r_gnt_idx] == '0) ? M_W'(fabric_wrap_inc(32'(r_gnt_idx), M))
                                                      : r_gnt_idx;
        end
      end
      default: w_state_d = ST_IDLE;
    endcase

    if (w_cfg_hit && (w_credit_d[bus.cfg_idx_i] > bus.cfg_weight_i)) begin
      w_credit_d[bus.cfg_idx_i] = bus.cfg_weight_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_gnt_idx   <= '0;
      r_gnt_oh    <= '0;
      r_gnt_valid <= 1'b0;
      r_reload    <= 1'b0;
      for (int unsigned i = 0; i < M; i++) begin
        r_weight[i] <= W_DEFAULT;
        r_credit[i] <= W_DEFAULT;
      end
    end else begin
      r_state     <= w_state_d;
      r_rr_ptr    <= w_rr_ptr_d;
      r_gnt_idx   <= w_gnt_idx_d;
      r_gnt_oh    <= w_gnt_oh_d;
      r_gnt_valid <= w_gnt_valid_d;
      r_reload    <= w_reload_d;
      r_weight    <= w_weight_d;
      r_credit    <= w_credit_d;
    end
  end

  assign bus.gnt_valid_o = r_gnt_valid;
  assign bus.gnt_oh_o    = r_gnt_oh;
  assign bus.gnt_idx_o   = r_gnt_idx;
  assign bus.reload_o    = r_reload;

endmodule

// File: tb/tb_fabric_wrr_scheduler.sv
// Directed self-checking bench for fabric_wrr_scheduler (M=4, W_W=4, DEFAULT_WEIGHT=1).
module tb_fabric_wrr_scheduler;

  logic clk;
  logic rst;

  fabric_wrr_scheduler_if #(.M(4), .W_W(4)) bus ();

  fabric_wrr_scheduler #(
    .M              (4),
    .W_W            (4),
    .DEFAULT_WEIGHT (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int trace[$];
  int seen;

  // 15 marks a reload pulse in a grant trace.
  int exp_a [7]  = '{0, 1, 2, 3, 15, 0, 1};
  int exp_b [13] = '{0, 1, 2, 3, 15, 0, 0, 0, 1, 2, 3, 15, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.req_i        = '0;
    bus.xfer_i       = 1'b0;
    bus.cfg_we_i     = 1'b0;
    bus.cfg_idx_i    = '0;
    bus.cfg_weight_i = '0;
    rst              = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic collect(input int cycles);
    trace.delete();
    repeat (cycles) begin
      tick();
      if (bus.gnt_valid_o) trace.push_back(int'(bus.gnt_idx_o));
      if (bus.reload_o) trace.push_back(15);
    end
  endtask

  initial begin
    rst              = 1'b1;
    bus.req_i        = '0;
    bus.xfer_i       = 1'b0;
    bus.cfg_we_i     = 1'b0;
    bus.cfg_idx_i    = '0;
    bus.cfg_weight_i = '0;

    // Reset values and first-grant latency
    @(negedge clk);
    chk("rst_valid", 32'(bus.gnt_valid_o), 0);
    chk("rst_oh", 32'(bus.gnt_oh_o), 0);
    chk("rst_idx", 32'(bus.gnt_idx_o), 0);
    chk("rst_reload", 32'(bus.reload_o), 0);
    rst = 1'b0;
    tick();
    chk("idle_valid", 32'(bus.gnt_valid_o), 0);
    bus.req_i = 4'b0100;
    tick();
    chk("lat_valid", 32'(bus.gnt_valid_o), 1);
    chk("lat_idx", 32'(bus.gnt_idx_o), 2);
    chk("lat_oh", 32'(bus.gnt_oh_o), 32'h4);

    // Equal weights, all requesting, xfer on every grant
    do_reset();
    bus.req_i  = 4'hF;
    bus.xfer_i = 1'b1;
    collect(12);
    chk("rr1_len", trace.size(), 7);
    for (int i = 0; i < 7; i++) chk($sformatf("rr1_ev%0d", i), trace[i], exp_a[i]);

    // Weight 3 on requester 0; first round still uses the reset credit of 1
    do_reset();
    bus.cfg_we_i     = 1'b1;
    bus.cfg_idx_i    = 2'd0;
    bus.cfg_weight_i = 4'd3;
    tick();
    bus.cfg_we_i = 1'b0;
    bus.req_i    = 4'hF;
    bus.xfer_i   = 1'b1;
    collect(23);
    chk("w3_len", trace.size(), 13);
    for (int i = 0; i < 13; i++) chk($sformatf("w3_ev%0d", i), trace[i], exp_b[i]);

    // Lock held under backpressure, withdraw, then xfer+withdraw together
    do_reset();
    bus.req_i = 4'b0001;
    tick();
    chk("hold_grant", 32'(bus.gnt_valid_o), 1);
    repeat (5) tick();
    chk("hold_valid", 32'(bus.gnt_valid_o), 1);
    chk("hold_oh", 32'(bus.gnt_oh_o), 32'h1);
    bus.req_i = 4'b0000;
    tick();
    chk("drop_valid", 32'(bus.gnt_valid_o), 0);
    chk("drop_reload", 32'(bus.reload_o), 0);
    bus.req_i = 4'b0001;
    tick();
    chk("regrant_valid", 32'(bus.gnt_valid_o), 1);
    chk("regrant_idx", 32'(bus.gnt_idx_o), 0);
    bus.xfer_i = 1'b1;
    bus.req_i  = 4'b0000;
    tick();
    chk("xw_valid", 32'(bus.gnt_valid_o), 0);
    bus.xfer_i = 1'b0;
    bus.req_i  = 4'b0001;
    tick();
    chk("xw_reload", 32'(bus.reload_o), 1);
    chk("xw_noval", 32'(bus.gnt_valid_o), 0);
    tick();
    chk("xw_grant", 32'(bus.gnt_valid_o), 1);

    // Zero weight is never granted and never reloads; re-enable with weight 2
    do_reset();
    bus.cfg_we_i     = 1'b1;
    bus.cfg_idx_i    = 2'd2;
    bus.cfg_weight_i = 4'd0;
    tick();
    bus.cfg_we_i = 1'b0;
    bus.req_i    = 4'b0100;
    seen         = 0;
    repeat (20) begin
      tick();
      if (bus.gnt_valid_o || bus.reload_o) seen++;
    end
    chk("w0_quiet", seen, 0);
    bus.cfg_we_i     = 1'b1;
    bus.cfg_weight_i = 4'd2;
    tick();
    bus.cfg_we_i = 1'b0;
    chk("wr_cyc_reload", 32'(bus.reload_o), 0);
    chk("wr_cyc_valid", 32'(bus.gnt_valid_o), 0);
    tick();
    chk("w2_reload", 32'(bus.reload_o), 1);
    tick();
    chk("w2_valid", 32'(bus.gnt_valid_o), 1);
    chk("w2_idx", 32'(bus.gnt_idx_o), 2);
    bus.xfer_i = 1'b1;
    tick();
    chk("w2_rel", 32'(bus.gnt_valid_o), 0);
    tick();
    chk("w2_burst_idx", 32'(bus.gnt_idx_o), 2);
    chk("w2_burst_val", 32'(bus.gnt_valid_o), 1);
    tick();
    tick();
    chk("w2_reload2", 32'(bus.reload_o), 1);

    // Async reset mid-lock restores default weights
    do_reset();
    bus.cfg_we_i     = 1'b1;
    bus.cfg_idx_i    = 2'd0;
    bus.cfg_weight_i = 4'd0;
    bus.req_i        = 4'b0010;
    tick();
    bus.cfg_we_i = 1'b0;
    chk("e_lock_valid", 32'(bus.gnt_valid_o), 1);
    chk("e_lock_idx", 32'(bus.gnt_idx_o), 1);
    #2 rst = 1'b1;
    #1;
    chk("e_rst_valid", 32'(bus.gnt_valid_o), 0);
    chk("e_rst_oh", 32'(bus.gnt_oh_o), 0);
    @(negedge clk);
    rst       = 1'b0;
    bus.req_i = 4'b0001;
    tick();
    chk("e_w0_valid", 32'(bus.gnt_valid_o), 1);
    chk("e_w0_idx", 32'(bus.gnt_idx_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
